countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 8, width of load value and count.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load_valid  input  1  requester offers load_value.
REQ-005 Port: load_ready  output  1  timer accepts a load this cycle.
REQ-006 Port: load_value  input  WIDTH  start value; sampled on load transfer.
REQ-007 Port: pause  input  1  level; freezes countdown while high.
REQ-008 Port: abort  input  1  cancels any countdown.
REQ-009 Port: count  output  WIDTH  registered current count.
REQ-010 Port: busy  output  1  high in RUN or PAUSE.
REQ-011 Port: expired  output  1  one-cycle registered pulse on reaching zero.

Function
REQ-012 States SHALL be IDLE, RUN, PAUSE, DONE; the state register SHALL be encoded in 2 bits.
REQ-013 load_ready SHALL equal (state is IDLE or DONE) AND NOT abort; a transfer occurs when load_valid AND load_ready are both high at a rising edge.
REQ-014 On a transfer with load_value != 0, the timer SHALL set count to load_value, store load_value in reload_reg, and enter RUN on the next cycle.
REQ-015 On a transfer with load_value == 0, the timer SHALL hold count at 0, pulse expired on the next cycle, and enter DONE.
REQ-016 In RUN with pause low, count SHALL decrement by 1 per cycle with no wrap below 0.
REQ-017 In RUN, the edge that takes count from 1 to 0 SHALL also assert expired for exactly that next cycle.
REQ-018 In RUN or PAUSE, pause high SHALL select PAUSE and hold count, and pause low SHALL return to RUN; a count from N to expiry SHALL take N plus the number of paused cycles.
REQ-019 Absent autoreload, the first cycle with count == 0 SHALL move the state to DONE; DONE SHALL hold count at 0 with busy low until a load or reset.
REQ-020 When abort is high in any state, the timer SHALL go to IDLE on the next edge with count 0, expired low, and no load accepted; abort SHALL have priority over load, pause, and expiry.
REQ-021 An abort in the same cycle that count reaches 0 SHALL suppress that expired pulse.
REQ-022 load_valid asserted while busy SHALL be ignored, with load_ready low and no state change.

Reset
REQ-023 reset high at a rising edge SHALL set state to IDLE, count to 0, reload_reg to 0, and expired to 0, which drives busy to 0 and load_ready to 1.
REQ-024 reset SHALL override abort, load, and pause, including mid-countdown and during an expired pulse.

Configuration
REQ-025 Macro COUNTDOWN_TIMER_AUTORELOAD_EN SHALL select whether autoreload is compiled in.
REQ-026 With COUNTDOWN_TIMER_AUTORELOAD_EN defined, RUN SHALL reload count from reload_reg in the cycle where count == 0, giving a period of N+1 cycles with expired once per period and the timer staying busy until abort or reset.
REQ-027 With COUNTDOWN_TIMER_AUTORELOAD_EN defined, a zero load SHALL still follow REQ-015 and SHALL never reload.
REQ-028 Without COUNTDOWN_TIMER_AUTORELOAD_EN, reload_reg and its logic SHALL be absent and REQ-019 SHALL apply.

Verification
REQ-029 Basic: load 5 -> count reads 5,4,3,2,1,0 on consecutive cycles, expired is high only in the count==0 cycle, then the state is DONE with busy 0 and load_ready 1.
REQ-030 Pause: load 4, hold pause high for 3 cycles at count 2 -> count holds 2 for 3 cycles and expired occurs 3 cycles later than without pause.
REQ-031 Abort: load 200, assert abort at count 150 -> next cycle count 0, IDLE, no expired; abort with load_valid in IDLE -> no transfer.
REQ-032 Zero and busy load: load 0 -> expired next cycle, DONE; load_valid with 9 while busy at count 3 -> ignored, count continues 2,1,0.
REQ-033 Reset mid-run: load 8, assert reset at count 4 -> next cycle count 0, IDLE, expired 0, load_ready 1.
REQ-034 Autoreload (macro defined): load 3 -> count sequence 3,2,1,0,3,2,1,0,..., expired every 4 cycles, and busy stays 1.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause, abort and a one-cycle expiry pulse.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN to reload from the last nonzero load at zero instead of stopping.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic expired_q, expired_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif
    assign busy = (state_q == RUN) || (state_q == PAUSE);
    assign load_ready = !busy && !abort;
    assign count = count_q;
    assign expired = expired_q;
    // RUN and PAUSE share one step: the state only records whether the last edge was paused
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expired_d = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (!busy) begin
            if (load_valid) begin
                count_d = load_value;
                state_d = (load_value == '0) ? DONE : RUN;
                expired_d = (load_value == '0);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                reload_d = load_value;
`endif
            end
        end else if (pause) begin
            state_d = PAUSE;
        end else if (count_q == '0) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            state_d = RUN;
            count_d = reload_q;
`else
            state_d = DONE;
`endif
        end else begin
            state_d = RUN;
            count_d = count_q - WIDTH'(1);
            expired_d = (count_q == WIDTH'(1));
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            expired_q <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            expired_q <= expired_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end
endmodule
